// File: rtl/mips32_mc.sv
// mips32_mc: multi-cycle MIPS32 subset core with one shared instruction/data
// memory port. Supports add/sub/and/or/slt, addi, lw, sw and beq; any other
// instruction parks the core in HALT until reset.
// Optional feature macro: MIPS32_MC_JUMP_EN adds the j instruction (opcode
// 0x02); without it opcode 0x02 halts.
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   memReq/memWe     transaction request / write strobe (held until memReady)
//   memAddr/memWData byte address (ADDR_W bits) / store data
//   memRData/memReady read data / transaction completion
//   pc, halted       current PC register / core stopped on unsupported opcode
//   dbgRegAddr/Data  combinational register-file debug read ($0 reads 0)
module mips32_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWData,
  input  logic [31:0]       memRData,
  input  logic              memReady,
  output logic [31:0]       pc,
  output logic              halted,
  input  logic [4:0]        dbgRegAddr,
  output logic [31:0]       dbgRegData
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
`ifdef MIPS32_MC_JUMP_EN
  localparam logic [3:0] JUMP   = 4'd11;
  localparam logic [5:0] OP_J   = 6'h02;
`endif
  localparam logic [3:0] HALT   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  logic [3:0]  state, next_state;
  logic [31:0] ir, a, b, alu_out, mdr;
  logic [31:0] regs [0:31];
  logic [31:0] addr_full;
  logic [31:0] alu_res;
  logic        alu_ok;

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sx;
  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm_sx = {{16{ir[15]}}, ir[15:0]};

  // R-type ALU; alu_ok drops for unsupported funct codes
  always_comb begin
    alu_res = 32'd0;
    alu_ok  = 1'b1;
    case (funct)
      F_ADD:   alu_res = a + b;
      F_SUB:   alu_res = a - b;
      F_AND:   alu_res = a & b;
      F_OR:    alu_res = a | b;
      F_SLT:   alu_res = {31'd0, $signed(a) < $signed(b)};
      default: alu_ok  = 1'b0;
    endcase
  end

  // Next-state and memory-port decode
  always_comb begin
    next_state = state;
    memReq     = 1'b0;
    memWe      = 1'b0;
    addr_full  = pc;
    case (state)
      FETCH: begin
        memReq = 1'b1;
        if (memReady) next_state = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state = EXEC;
          OP_LW, OP_SW: next_state = MEMADR;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
`ifdef MIPS32_MC_JUMP_EN
          OP_J:         next_state = JUMP;
`endif
          default:      next_state = HALT;
        endcase
      end
      MEMADR: next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        memReq    = 1'b1;
        addr_full = alu_out;
        if (memReady) next_state = MEMWB;
      end
      MEMWR: begin
        memReq    = 1'b1;
        memWe     = 1'b1;
        addr_full = alu_out;
        if (memReady) next_state = FETCH;
      end
      EXEC:   next_state = alu_ok ? ALUWB : HALT;
      ADDIEX: next_state = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH: next_state = FETCH;
`ifdef MIPS32_MC_JUMP_EN
      JUMP:   next_state = FETCH;
`endif
      HALT:   next_state = HALT;
      default: next_state = HALT;
    endcase
    // No request may be seen while reset is held, whatever the state
    if (rst) memReq = 1'b0;
  end

  assign memAddr  = addr_full[ADDR_W-1:0];
  assign memWData = b;

  // State, PC and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      halted  <= 1'b0;
      ir      <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      state  <= next_state;
      halted <= (next_state == HALT);
      case (state)
        FETCH: if (memReady) begin
          ir <= memRData;
          pc <= pc + 32'd4;
        end
        DECODE: begin
          a <= regs[rs];
          b <= regs[rt];
        end
        MEMADR, ADDIEX: alu_out <= a + imm_sx;
        EXEC:   alu_out <= alu_res;
        MEMRD:  if (memReady) mdr <= memRData;
        MEMWB:  if (rt != 5'd0) regs[rt] <= mdr;
        ALUWB:  if (rd != 5'd0) regs[rd] <= alu_out;
        ADDIWB: if (rt != 5'd0) regs[rt] <= alu_out;
        // pc already holds the address of the next sequential instruction
        BRANCH: if (a == b) pc <= pc + {imm_sx[29:0], 2'b00};
`ifdef MIPS32_MC_JUMP_EN
        JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
`endif
        default: ;
      endcase
    end
  end

  assign dbgRegData = (dbgRegAddr == 5'd0) ? 32'd0 : regs[dbgRegAddr];

endmodule

// File: doc/mips32_mc.md
MIPS32_MC -- requirements
Module: mips32_mc

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 The block SHALL have parameter ADDR_W, default 32: byte-address width driven on memAddr; PC bits above ADDR_W are dropped.
REQ-003 The block SHALL have the following ports, one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- memReq  out  1  memory transaction request.
- memWe  out  1  1 = write, 0 = read; valid while memReq=1.
- memAddr  out  ADDR_W  byte address; valid while memReq=1.
- memWData  out  32  store data; valid while memReq=1 and memWe=1.
- memRData  in  32  read data; sampled only in a cycle with memReq=1, memWe=0 and memReady=1.
- memReady  in  1  completes the pending transaction in the cycle it is high with memReq=1.
- pc  out  32  current PC register.
- halted  out  1  core stopped on an unsupported instruction.
- dbgRegAddr  in  5  debug register-file read index.
- dbgRegData  out  32  combinational read of register dbgRegAddr ($0 reads 0).

Function
REQ-004 The block SHALL be a multi-cycle MIPS32 core with one shared instruction/data memory port.
REQ-005 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
REQ-006 In FETCH, MEMRD and MEMWR, memReq SHALL be 1; in all other states it SHALL be 0.
REQ-007 Addr, we and wdata SHALL stay constant until memReady=1. The FSM SHALL stay in its state while memReady=0.
REQ-008 FETCH with memReady=1 SHALL latch IR<=memRData, set PC<=PC+4 and move to DECODE.
REQ-009 DECODE SHALL read rs/rt into A/B and go to the next state by opcode:
- 0x00 -> EXEC
- 0x23 (lw) and 0x2B (sw) -> MEMADR
- 0x04 (beq) -> BRANCH
- 0x08 (addi) -> ADDIEX
- 0x02 (j) -> JUMP, only under MIPS32_MC_JUMP_EN
- anything else -> HALT
REQ-010 EXEC SHALL support these funct codes:
- 0x20 add, 0x22 sub, 0x24 and, 0x25 or: wrap modulo 2^32
- 0x2A slt: signed compare
- any other funct -> HALT
REQ-011 MEMADR SHALL compute A+signext(imm16). lw then goes to MEMRD, sw to MEMWR.
REQ-012 MEMRD completion SHALL go to MEMWB, which writes rt. MEMWR completion SHALL go to FETCH.
REQ-013 ALUWB SHALL write rd; ADDIWB SHALL write rt; both then go to FETCH.
REQ-014 BRANCH SHALL set PC<=PC+(signext(imm16)<<2) when A==B, else leave PC unchanged; then go to FETCH.
REQ-015 Writes to $0 SHALL be discarded; $0 SHALL always read 0.
REQ-016 HALT SHALL be absorbing until rst; halted=1 and memReq=0 in HALT.
REQ-017 With memReady tied high, cycles per instruction SHALL be:
- R-type 4, addi 4, sw 4
- lw 5
- beq 3, j 3
REQ-018 Each memReady=0 cycle SHALL add exactly one cycle.
REQ-019 memAddr SHALL equal the full-precision address truncated to ADDR_W. Bits [1:0] SHALL be passed through unchecked.

Reset
REQ-020 While rst=1, memReq SHALL be 0.
REQ-021 The reset edge SHALL set state=FETCH, pc=RESET_PC, halted=0, IR=0, A=B=ALUOut=0, and all 32 registers=0.
REQ-022 rst asserted mid-transaction SHALL abandon it. No register-file or PC update from the abandoned transaction SHALL occur.
REQ-023 The first memReq after rst deassert SHALL be a fetch at RESET_PC.

Configuration
REQ-024 Macro MIPS32_MC_JUMP_EN SHALL control the j instruction.
- Defined: opcode 0x02 goes DECODE->JUMP, which sets PC<={PC[31:28], IR[25:0], 2'b00}, then FETCH.
- Undefined: JUMP logic is absent and opcode 0x02 goes to HALT.

Verification
REQ-025 Zero-wait program "addi $1,$0,5; addi $2,$0,7; add $3,$1,$2" from PC 0 -> dbgRegData($3)=12 and pc=0x0C after exactly 12 cycles.
REQ-026 "sw $3,0x40($0); lw $4,0x40($0)" with memReady low 3 cycles per access:
- memReq, memAddr=0x40 and memWData=12 stable during waits;
- $4=12;
- lw takes 8 cycles.
REQ-027 beq at 0x10 with offset 2:
- taken ($1==$1) -> pc=0x1C;
- not taken ($1!=$2) -> pc=0x14;
- 3 cycles each.
REQ-028 Edge values:
- "addi $0,$0,9" -> $0 reads 0;
- sub 0-1 -> 0xFFFFFFFF;
- slt of 0xFFFFFFFF vs 1 -> 1.
REQ-029 Opcode 0x3F -> halted=1 and memReq=0 for 20+ cycles. rst pulse mid-fetch -> halted=0 and next fetch at RESET_PC.
REQ-030 j 0x10 at PC 0x00:
- with MIPS32_MC_JUMP_EN -> pc=0x40 after 3 cycles;
- without it -> halted=1.
